// File: rtl/dmem_axi_bridge.sv
// Data-side membus to AXI4 single-beat bridge. One outstanding load or store,
// relocated by dram_base at accept time.
module dmem_axi_bridge #(
  parameter int AXI_ID_W   = 1,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,

  input  logic [31:0]           dram_base,

  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [31:0]           mem_addr,
  input  logic                  mem_wen,
  input  logic [3:0]            mem_wmask,
  input  logic [31:0]           mem_wdata,
  output logic                  mem_rvalid,
  output logic [31:0]           mem_rdata,
  output logic                  err,

  output logic [AXI_ID_W-1:0]   M_AXI_AWID,
  output logic [AXI_ADDR_W-1:0] M_AXI_AWADDR,
  output logic [7:0]            M_AXI_AWLEN,
  output logic [2:0]            M_AXI_AWSIZE,
  output logic [1:0]            M_AXI_AWBURST,
  output logic [1:0]            M_AXI_AWLOCK,
  output logic [3:0]            M_AXI_AWCACHE,
  output logic [2:0]            M_AXI_AWPROT,
  output logic [3:0]            M_AXI_AWQOS,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,

  output logic [AXI_DATA_W-1:0] M_AXI_WDATA,
  output logic [3:0]            M_AXI_WSTRB,
  output logic                  M_AXI_WLAST,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,

  input  logic [AXI_ID_W-1:0]   M_AXI_BID,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,

  output logic [AXI_ID_W-1:0]   M_AXI_ARID,
  output logic [AXI_ADDR_W-1:0] M_AXI_ARADDR,
  output logic [7:0]            M_AXI_ARLEN,
  output logic [2:0]            M_AXI_ARSIZE,
  output logic [1:0]            M_AXI_ARBURST,
  output logic [1:0]            M_AXI_ARLOCK,
  output logic [3:0]            M_AXI_ARCACHE,
  output logic [2:0]            M_AXI_ARPROT,
  output logic [3:0]            M_AXI_ARQOS,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,

  input  logic [AXI_ID_W-1:0]   M_AXI_RID,
  input  logic [AXI_DATA_W-1:0] M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RLAST,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t                state, state_nxt;
  logic [31:0]           addr;
  logic [AXI_DATA_W-1:0] wdata;
  logic [3:0]            wmask;
  logic                  ar_valid, aw_valid, w_valid;
  logic                  accept, ar_fire, aw_fire, w_fire;
  logic                  r_fire, b_fire, wr_done;
  logic                  unused_ok;

  assign accept  = mem_valid && (state == IDLE);
  assign ar_fire = ar_valid && M_AXI_ARREADY;
  assign aw_fire = aw_valid && M_AXI_AWREADY;
  assign w_fire  = w_valid && M_AXI_WREADY;
  assign r_fire  = (state == RD_DATA) && M_AXI_RVALID;
  assign b_fire  = (state == WR_RESP) && M_AXI_BVALID;
  // Write phase ends once neither channel still has a pending beat after this edge.
  assign wr_done = (!aw_valid || M_AXI_AWREADY) && (!w_valid || M_AXI_WREADY);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mem_valid)     state_nxt = mem_wen ? WR_REQ : RD_ADDR;
      RD_ADDR: if (M_AXI_ARREADY) state_nxt = RD_DATA;
      RD_DATA: if (M_AXI_RVALID)  state_nxt = RESP;
      WR_REQ:  if (wr_done)       state_nxt = WR_RESP;
      WR_RESP: if (M_AXI_BVALID)  state_nxt = RESP;
      RESP:                       state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      addr      <= '0;
      wdata     <= '0;
      wmask     <= '0;
      ar_valid  <= 1'b0;
      aw_valid  <= 1'b0;
      w_valid   <= 1'b0;
      mem_rdata <= '0;
      err       <= 1'b0;
    end else begin
      if (accept) begin
        addr     <= dram_base + {mem_addr[31:2], 2'b00};
        wdata    <= mem_wdata;
        wmask    <= mem_wmask;
        ar_valid <= !mem_wen;
        aw_valid <= mem_wen;
        w_valid  <= mem_wen;
      end
      if (ar_fire) ar_valid <= 1'b0;
      if (aw_fire) aw_valid <= 1'b0;
      if (w_fire)  w_valid  <= 1'b0;
      if (r_fire) begin
        mem_rdata <= M_AXI_RDATA;
        if (M_AXI_RRESP != 2'b00) err <= 1'b1;
      end
      if (b_fire && (M_AXI_BRESP != 2'b00)) err <= 1'b1;
    end
  end

  assign mem_ready     = (state == IDLE);
  assign mem_rvalid    = (state == RESP);
  assign M_AXI_RREADY  = (state == RD_DATA);
  assign M_AXI_BREADY  = (state == WR_RESP);

  assign M_AXI_ARID    = '0;
  assign M_AXI_ARADDR  = addr;
  assign M_AXI_ARLEN   = 8'd0;
  assign M_AXI_ARSIZE  = 3'b010;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARLOCK  = 2'b00;
  assign M_AXI_ARCACHE = 4'b0011;
  assign M_AXI_ARPROT  = 3'd0;
  assign M_AXI_ARQOS   = 4'd0;
  assign M_AXI_ARVALID = ar_valid;

  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = addr;
  assign M_AXI_AWLEN   = 8'd0;
  assign M_AXI_AWSIZE  = 3'b010;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWLOCK  = 2'b00;
  assign M_AXI_AWCACHE = 4'b0011;
  assign M_AXI_AWPROT  = 3'd0;
  assign M_AXI_AWQOS   = 4'd0;
  assign M_AXI_AWVALID = aw_valid;

  assign M_AXI_WDATA   = wdata;
  assign M_AXI_WSTRB   = wmask;
  assign M_AXI_WLAST   = 1'b1;
  assign M_AXI_WVALID  = w_valid;

  // Response IDs, RLAST and the byte offset carry no information for single-beat word access.
  assign unused_ok = ^{M_AXI_BID, M_AXI_RID, M_AXI_RLAST, mem_addr[1:0]};

endmodule

// File: tb/tb_dmem_axi_bridge.sv
// Directed bench for dmem_axi_bridge: scripted AXI slave plus a response
// scoreboard that checks data, err and latency on every mem_rvalid.
`timescale 1ns/1ps
module tb_dmem_axi_bridge;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [31:0] dram_base = '0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [31:0] mem_addr = '0;
  logic        mem_wen = 1'b0;
  logic [3:0]  mem_wmask = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        err;

  logic [0:0]  M_AXI_AWID, M_AXI_ARID, M_AXI_BID, M_AXI_RID;
  logic [31:0] M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA, M_AXI_RDATA;
  logic [7:0]  M_AXI_AWLEN, M_AXI_ARLEN;
  logic [2:0]  M_AXI_AWSIZE, M_AXI_ARSIZE, M_AXI_AWPROT, M_AXI_ARPROT;
  logic [1:0]  M_AXI_AWBURST, M_AXI_ARBURST, M_AXI_AWLOCK, M_AXI_ARLOCK;
  logic [3:0]  M_AXI_AWCACHE, M_AXI_ARCACHE, M_AXI_AWQOS, M_AXI_ARQOS, M_AXI_WSTRB;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WLAST, M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;

  dmem_axi_bridge dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .dram_base(dram_base),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .err(err),
    .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
    .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWLOCK(M_AXI_AWLOCK),
    .M_AXI_AWCACHE(M_AXI_AWCACHE), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWQOS(M_AXI_AWQOS),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BID(M_AXI_BID), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
    .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARLOCK(M_AXI_ARLOCK),
    .M_AXI_ARCACHE(M_AXI_ARCACHE), .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARQOS(M_AXI_ARQOS),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RID(M_AXI_RID), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  initial forever #5 ACLK = ~ACLK;

  typedef struct { logic [31:0] rdata; logic err; int lat; int acc; } rsp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } wexp_t;

  rsp_t        exp_rsp_q[$];
  logic [31:0] exp_ar_q[$];
  wexp_t       exp_w_q[$];

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
  logic [31:0] rd_data = '0;
  logic [1:0]  rd_resp = '0, wr_resp = '0;

  initial forever begin
    @(posedge ACLK);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_msg(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
  endtask

  // Scoreboard monitor: every mem_rvalid pulse consumes one expected response.
  initial begin : monitor
    rsp_t r;
    forever begin
      @(negedge ACLK);
      if (ARESETN && mem_rvalid) begin
        if (exp_rsp_q.size() == 0) fail_msg("unexpected_rvalid");
        else begin
          r = exp_rsp_q.pop_front();
          chk("rsp_rdata", mem_rdata, r.rdata);
          chk("rsp_err", {31'd0, err}, {31'd0, r.err});
          chk("rsp_latency", cyc - r.acc, r.lat);
          chk("ready_in_resp", {31'd0, mem_ready}, 32'd0);
        end
      end
    end
  end

  // Read slave: AR accepted after ar_delay cycles, R beat r_delay cycles later.
  initial begin : slave_rd
    int cnt;
    logic [31:0] ea;
    M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RDATA = '0;
    M_AXI_RRESP = '0; M_AXI_RID = '0; M_AXI_RLAST = 1'b0;
    forever begin
      @(negedge ACLK);
      if (ARESETN && M_AXI_ARVALID) begin
        ea = '0;
        if (exp_ar_q.size() == 0) fail_msg("unexpected_ar");
        else ea = exp_ar_q[0];
        cnt = 0;
        while (ARESETN && cnt < ar_delay) begin
          chk("ar_hold_valid", {31'd0, M_AXI_ARVALID}, 32'd1);
          chk("ar_hold_addr", M_AXI_ARADDR, ea);
          chk("busy_ready_ar", {31'd0, mem_ready}, 32'd0);
          cnt++;
          @(negedge ACLK);
        end
        if (ARESETN) begin
          chk("araddr", M_AXI_ARADDR, ea);
          chk("arvalid", {31'd0, M_AXI_ARVALID}, 32'd1);
          if (exp_ar_q.size() > 0) void'(exp_ar_q.pop_front());
          M_AXI_ARREADY = 1'b1;
          @(negedge ACLK);
          M_AXI_ARREADY = 1'b0;
          cnt = 0;
          while (ARESETN && cnt < r_delay) begin
            chk("busy_ready_r", {31'd0, mem_ready}, 32'd0);
            chk("ar_dropped", {31'd0, M_AXI_ARVALID}, 32'd0);
            @(negedge ACLK);
            cnt++;
          end
          if (ARESETN) begin
            M_AXI_RDATA = rd_data; M_AXI_RRESP = rd_resp;
            M_AXI_RLAST = 1'b1; M_AXI_RVALID = 1'b1;
            cnt = 0;
            while (ARESETN && !M_AXI_RREADY && cnt < 50) begin
              @(negedge ACLK);
              cnt++;
            end
            if (ARESETN && !M_AXI_RREADY) fail_msg("rready_timeout");
            @(negedge ACLK);
          end
        end
        M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0; M_AXI_RRESP = '0;
      end
    end
  end

  // Write slave: AW and W readies delayed independently, then B after b_delay.
  initial begin : slave_wr
    int n;
    logic aw_done, w_done;
    wexp_t e;
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
    M_AXI_BRESP = '0; M_AXI_BID = '0;
    forever begin
      @(negedge ACLK);
      if (ARESETN && (M_AXI_AWVALID || M_AXI_WVALID)) begin
        e = '{addr: 32'd0, data: 32'd0, strb: 4'd0};
        if (exp_w_q.size() == 0) fail_msg("unexpected_write");
        else e = exp_w_q.pop_front();
        chk("awaddr", M_AXI_AWADDR, e.addr);
        chk("wdata", M_AXI_WDATA, e.data);
        chk("wstrb", {28'd0, M_AXI_WSTRB}, {28'd0, e.strb});
        chk("aw_w_together", {30'd0, M_AXI_AWVALID, M_AXI_WVALID}, 32'd3);
        aw_done = 1'b0; w_done = 1'b0; n = 0;
        while (ARESETN && !(aw_done && w_done) && n < 50) begin
          chk("awvalid_state", {31'd0, M_AXI_AWVALID}, {31'd0, !aw_done});
          chk("wvalid_state", {31'd0, M_AXI_WVALID}, {31'd0, !w_done});
          chk("bready_early", {31'd0, M_AXI_BREADY}, 32'd0);
          if (!aw_done) chk("awaddr_hold", M_AXI_AWADDR, e.addr);
          if (!w_done) chk("wdata_hold", M_AXI_WDATA, e.data);
          M_AXI_AWREADY = !aw_done && (n >= aw_delay);
          M_AXI_WREADY  = !w_done && (n >= w_delay);
          @(negedge ACLK);
          if (M_AXI_AWREADY) aw_done = 1'b1;
          if (M_AXI_WREADY) w_done = 1'b1;
          M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
          n++;
        end
        if (ARESETN && !(aw_done && w_done)) fail_msg("write_hs_timeout");
        n = 0;
        while (ARESETN && n < b_delay) begin
          @(negedge ACLK);
          n++;
        end
        if (ARESETN) begin
          M_AXI_BRESP = wr_resp; M_AXI_BVALID = 1'b1;
          n = 0;
          while (ARESETN && !M_AXI_BREADY && n < 50) begin
            @(negedge ACLK);
            n++;
          end
          if (ARESETN && !M_AXI_BREADY) fail_msg("bready_timeout");
          @(negedge ACLK);
        end
        M_AXI_BVALID = 1'b0; M_AXI_BRESP = '0;
      end
    end
  end

  task automatic do_req(input logic wen, input logic [31:0] base, input logic [31:0] a,
                        input logic [3:0] m, input logic [31:0] d, input bit push,
                        input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    int n = 0;
    @(negedge ACLK);
    while (!mem_ready && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    if (!mem_ready) fail_msg("ready_timeout");
    dram_base = base; mem_addr = a; mem_wen = wen; mem_wmask = m; mem_wdata = d;
    mem_valid = 1'b1;
    if (push) exp_rsp_q.push_back('{rdata: exp_rdata, err: exp_err, lat: exp_lat, acc: cyc});
    @(posedge ACLK);
    #1;
    mem_valid = 1'b0;
    dram_base = 32'h5A5A_0000; mem_addr = 32'hFFFF_FFFC; mem_wdata = ~d; mem_wmask = ~m;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_rsp_q.size() != 0 && n < 300) begin
      @(negedge ACLK);
      n++;
    end
    if (exp_rsp_q.size() != 0) fail_msg("response_timeout");
    @(negedge ACLK);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared + 1, mismatched);
    $finish;
  end

  initial begin : stimulus
    int n;
    repeat (3) @(negedge ACLK);
    chk("rst_ready", {31'd0, mem_ready}, 32'd1);
    chk("rst_valids", {27'd0, M_AXI_ARVALID, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_RREADY, M_AXI_BREADY}, 32'd0);
    chk("rst_rvalid", {31'd0, mem_rvalid}, 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("ar_const", {6'd0, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS},
        {6'd0, 8'd0, 3'b010, 2'b01, 2'b00, 4'b0011, 3'd0, 4'd0});
    chk("aw_const", {6'd0, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS},
        {6'd0, 8'd0, 3'b010, 2'b01, 2'b00, 4'b0011, 3'd0, 4'd0});
    chk("ids_wlast", {29'd0, M_AXI_ARID, M_AXI_AWID, M_AXI_WLAST}, 32'd1);
    #2 ARESETN = 1'b1;
    @(negedge ACLK);
    chk("ready_after_rst", {31'd0, mem_ready}, 32'd1);

    // Zero-wait load
    rd_data = 32'hDEAD_BEEF; rd_resp = 2'b00;
    exp_ar_q.push_back(32'h2000_0104);
    do_req(1'b0, 32'h2000_0000, 32'h0000_0104, 4'h0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 3);
    wait_done();

    // Zero-wait store, unaligned address, rdata holds previous load value
    wr_resp = 2'b00;
    exp_w_q.push_back('{addr: 32'h2000_0010, data: 32'h1234_5678, strb: 4'b0110});
    do_req(1'b1, 32'h2000_0000, 32'h0000_0013, 4'b0110, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF, 1'b0, 3);
    wait_done();

    // W accepted three cycles before AW
    aw_delay = 3; w_delay = 0;
    exp_w_q.push_back('{addr: 32'h2000_0040, data: 32'hA5A5_A5A5, strb: 4'b1111});
    do_req(1'b1, 32'h2000_0000, 32'h0000_0040, 4'b1111, 32'hA5A5_A5A5, 1'b1, 32'hDEAD_BEEF, 1'b0, 6);
    wait_done();
    aw_delay = 0;

    // AR backpressure then delayed R
    ar_delay = 5; r_delay = 4; rd_data = 32'h0BAD_F00D;
    exp_ar_q.push_back(32'h2000_0200);
    do_req(1'b0, 32'h2000_0000, 32'h0000_0200, 4'h0, 32'h0, 1'b1, 32'h0BAD_F00D, 1'b0, 12);
    wait_done();
    ar_delay = 0; r_delay = 0;

    // SLVERR on a store with empty strobe, err must stick
    wr_resp = 2'b10;
    exp_w_q.push_back('{addr: 32'h2000_0008, data: 32'hFFFF_FFFF, strb: 4'b0000});
    do_req(1'b1, 32'h2000_0000, 32'h0000_0008, 4'b0000, 32'hFFFF_FFFF, 1'b1, 32'h0BAD_F00D, 1'b1, 3);
    wait_done();
    wr_resp = 2'b00;

    rd_data = 32'h1122_3344;
    exp_ar_q.push_back(32'h2000_000C);
    do_req(1'b0, 32'h2000_0000, 32'h0000_000C, 4'h0, 32'h0, 1'b1, 32'h1122_3344, 1'b1, 3);
    wait_done();

    // Address wrap-around
    rd_data = 32'hCAFE_F00D;
    exp_ar_q.push_back(32'h0000_0010);
    do_req(1'b0, 32'hFFFF_FFF0, 32'h0000_0020, 4'h0, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b1, 3);
    wait_done();

    // Reset while waiting for R
    r_delay = 20; rd_data = 32'h7777_7777;
    exp_ar_q.push_back(32'h2000_0300);
    do_req(1'b0, 32'h2000_0000, 32'h0000_0300, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, 0);
    n = 0;
    while (!M_AXI_RREADY && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    if (!M_AXI_RREADY) fail_msg("rd_data_not_reached");
    #2 ARESETN = 1'b0;
    #1;
    chk("midrst_rready", {31'd0, M_AXI_RREADY}, 32'd0);
    chk("midrst_ready", {31'd0, mem_ready}, 32'd1);
    chk("midrst_rdata", mem_rdata, 32'd0);
    chk("midrst_err", {31'd0, err}, 32'd0);
    chk("midrst_valids", {29'd0, M_AXI_ARVALID, M_AXI_AWVALID, M_AXI_WVALID}, 32'd0);
    @(negedge ACLK);
    @(negedge ACLK);
    r_delay = 0;
    #2 ARESETN = 1'b1;
    @(negedge ACLK);
    chk("ready_after_midrst", {31'd0, mem_ready}, 32'd1);

    rd_data = 32'h55AA_55AA;
    exp_ar_q.push_back(32'h2000_0004);
    do_req(1'b0, 32'h2000_0000, 32'h0000_0004, 4'h0, 32'h0, 1'b1, 32'h55AA_55AA, 1'b0, 3);
    wait_done();

    repeat (5) @(negedge ACLK);
    chk("ar_q_empty", exp_ar_q.size(), 32'd0);
    chk("w_q_empty", exp_w_q.size(), 32'd0);
    chk("rsp_q_empty", exp_rsp_q.size(), 32'd0);
    chk("final_ready", {31'd0, mem_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dmem_axi_bridge.md
# dmem_axi_bridge

Data-side memory adapter for the CPU core. It converts single-word load/store requests on the core's plain membus into single-beat AXI4 master reads and writes, relocated by the DRAM base programmed in BOOTCTRL. It sits directly downstream of `core_port`'s data bus and upstream of the AXI interconnect, alongside the instruction-fetch read adapter.

## Interface
Parameters:
- `AXI_ID_W`, 1, AXI ID width; all IDs are driven 0.
- `AXI_ADDR_W`, 32, AXI address width; only 32 is supported.
- `AXI_DATA_W`, 32, AXI data width; only 32 is supported.

Ports:
- Reset is asynchronous and active-low. One clock only.
- `ACLK`  in  1  clock.
- `ARESETN`  in  1  async active-low reset.
- `dram_base`  in  32  physical base added to every core address; sampled at request accept.
- `mem_valid`  in  1  request valid.
- `mem_ready`  out  1  bridge can accept a request.
- `mem_addr`  in  32  byte address; bits [1:0] are ignored.
- `mem_wen`  in  1  1 = store, 0 = load.
- `mem_wmask`  in  4  store byte enables.
- `mem_wdata`  in  32  store data.
- `mem_rvalid`  out  1  one-cycle response pulse; issued for both loads and stores.
- `mem_rdata`  out  32  load data; valid with `mem_rvalid`.
- `err`  out  1  sticky flag: some response had `RRESP` or `BRESP` != 0.
- AW channel (out, except `M_AXI_AWREADY` in): `M_AXI_AWID`, `AWADDR`, `AWLEN`[8], `AWSIZE`[3], `AWBURST`[2], `AWLOCK`[2], `AWCACHE`[4], `AWPROT`[3], `AWQOS`[4], `AWVALID`.
- W channel (out, except `M_AXI_WREADY` in): `M_AXI_WDATA`[32], `WSTRB`[4], `WLAST`, `WVALID`.
- B channel (in, except `M_AXI_BREADY` out): `M_AXI_BID`, `BRESP`[2], `BVALID`.
- AR channel (out, except `M_AXI_ARREADY` in): mirror of AW with the `AR` prefix.
- R channel (in, except `M_AXI_RREADY` out): `M_AXI_RID`, `RDATA`[32], `RRESP`[2], `RLAST`, `RVALID`.

## Operation
- Constant AXI fields:
  - `LEN` = 0, `SIZE` = 3'b010, `BURST` = 2'b01, `LOCK` = 0, `CACHE` = 4'b0011, `PROT` = 0, `QOS` = 0, ID = 0.
  - `WLAST` = 1.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
- `mem_ready` = (state == IDLE). A request is accepted when `mem_valid & mem_ready`.
- On accept, latch:
  - `addr` = `dram_base` + {`mem_addr`[31:2], 2'b00], computed modulo 2^32 (wrap-around is silent).
  - `wdata`, `wmask`.
  - Next state is RD_ADDR if `mem_wen` = 0, otherwise WR_REQ.
- RD_ADDR: `ARVALID` = 1 with `ARADDR` = `addr`. On `ARREADY`, go to RD_DATA.
- RD_DATA: `RREADY` = 1. On `RVALID`:
  - Capture `RDATA` into `mem_rdata`.
  - If `RRESP` != 0, set `err`.
  - Go to RESP. `RLAST` and `RID` are ignored.
- WR_REQ: `AWVALID` and `WVALID` are asserted together on entry, with `WSTRB` = `wmask` and `WDATA` = `wdata`.
  - Each VALID drops independently after its own handshake.
  - Go to WR_RESP in the cycle where the last outstanding handshake completes; simultaneous handshakes are allowed.
- WR_RESP: `BREADY` = 1. On `BVALID`: if `BRESP` != 0, set `err`; go to RESP.
- RESP: `mem_rvalid` = 1 for exactly one cycle, then IDLE.
  - For stores, `mem_rdata` holds its previous value.
- At most one transaction is outstanding; `mem_valid` is not sampled outside IDLE.
- `err` clears only on reset.
- An all-zero `wmask` is still issued as a write with `WSTRB` = 0.

## Timing
- Reset values (async on `ARESETN` low):
  - state = IDLE, all VALID/READY outputs 0 except `mem_ready`.
  - `mem_rvalid` = 0, `mem_rdata` = 0, `err` = 0.
- `mem_ready` is 1 from the first clock after reset release.
- Reset mid-transaction abandons the AXI transfer immediately and drops all VALIDs. The interconnect is reset by the same `ARESETN`.
- Load latency with zero-wait slave (ARREADY same cycle, RVALID in the cycle after AR):
  - Accept at cycle 0, AR handshake at cycle 1, R beat at cycle 2.
  - `mem_rvalid` at cycle 3, `mem_ready` again at cycle 4.
- Store latency with zero-wait slave: AW+W at cycle 1, B at cycle 2, `mem_rvalid` at cycle 3.
- AXI VALIDs are registered outputs. Once asserted, VALID and its payload stay stable until the handshake.
- No combinational path from `mem_valid` to any AXI output.

## Test plan
- Load, `dram_base` = 0x2000_0000, `mem_addr` = 0x0000_0104, slave returns 0xDEADBEEF -> `ARADDR` = 0x2000_0104; `mem_rvalid` at cycle 3 with `mem_rdata` = 0xDEADBEEF; `err` = 0.
- Store, `mem_addr` = 0x0000_0013, `mem_wmask` = 4'b0110, `mem_wdata` = 0x1234_5678:
  - `AWADDR` = base + 0x10, `WSTRB` = 0110, `WDATA` = 0x12345678.
  - One `mem_rvalid` pulse after B.
- Skewed write handshake: `WREADY` 3 cycles before `AWREADY` -> `WVALID` drops after its beat, `AWVALID` holds, `BREADY` rises only after the AW handshake; one response.
- Backpressure: `ARREADY` low for 5 cycles, then `RVALID` delayed 4 cycles -> `ARVALID`/`ARADDR` stable throughout; `mem_ready` = 0 until after `mem_rvalid`.
- Error: `BRESP` = 2'b10 on a store, then a clean load -> `err` = 1 and stays 1; the load still returns its data.
- Wrap and reset: `dram_base` = 0xFFFF_FFF0 with `mem_addr` = 0x20 gives `ARADDR` = 0x0000_0010. Assert `ARESETN` low during RD_DATA -> outputs go to reset values at once; the next load works normally.
